battle_sequencer: RTL



---
 rtl/battle_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/battle_sequencer.sv
// Battle-loop sequencer: MENU -> START -> ACTION -> ATTACK/DODGE with a one-entry instruction slot.
// Define BATTLE_SEQ_ATK_TIMEOUT_EN to bound the ATTACK wait by ATK_TIMEOUT clocks.
module battle_sequencer #(
  parameter int HP_W         = 8,
  parameter int MON_HP_MAX   = 100,
  parameter int HEAL_AMT     = 10,
  parameter int DODGE_CYCLES = 1000,
  parameter int ATK_TIMEOUT  = 500,
  parameter int RND_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       key,
  input  logic             isDeath,
  input  logic             atkPass,
  input  logic [HP_W-1:0]  dmgMon,
  input  logic             isDmgComplete,
  input  logic [7:0]       damage,
  input  logic             heal,
  input  logic             instrReady,
  output logic [7:0]       state,
  output logic [15:0]      playerInstruction,
  output logic             instrValid,
  output logic             isMove,
  output logic [HP_W-1:0]  monHP,
  output logic             startDmg,
  output logic [RND_W-1:0] roundCnt,
  output logic             win
);
  localparam logic [3:0] PG_MENU = 4'h1, PG_START = 4'h8, PG_DODGE = 4'h9,
                         PG_ATK  = 4'hA, PG_ACT   = 4'hB;
  localparam logic [3:0] K_W = 4'd1, K_A = 4'd2, K_D = 4'd4, K_J = 4'd5, K_SPACE = 4'd8;
  localparam logic [3:0] OP_HPY = 4'd1, OP_DPY = 4'd2, OP_MOV = 4'd5;
  localparam int DT_W = $clog2(DODGE_CYCLES + 1);

  logic [3:0]       page_q, page_d, sub_q, sub_d;
  logic [DT_W-1:0]  dtmr_q, dtmr_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic             win_q, win_d, iv_q, iv_d, mv_q, mv_d, sd_q, sd_d;
  logic [3:0]       iop_q, iop_d;
  logic [7:0]       iarg_q, iarg_d;

  logic            in_dodge, dodge_hit, dodge_mov, dodge_exp, is_wasd;
  logic            menu_go, act_j, atk_pass, atk_kill, atk_exp;
  logic [HP_W:0]   hp_sum;
  logic            iss, pend;
  logic [3:0]      iss_op;
  logic [7:0]      iss_arg;
  logic [8:0]      dsum;

  // Event decode shared by the next-state and output logic; death masks every DODGE event.
  assign is_wasd   = (key >= K_W) && (key <= K_D);
  assign in_dodge  = (page_q == PG_DODGE);
  assign dodge_hit = in_dodge && !isDeath && isDmgComplete;
  assign dodge_mov = in_dodge && !isDeath && !isDmgComplete && is_wasd;
  assign dodge_exp = in_dodge && !isDeath && (dtmr_q <= DT_W'(1));
  assign menu_go   = (page_q == PG_MENU) && (key == K_SPACE);
  assign act_j     = (page_q == PG_ACT) && (key == K_J);
  assign hp_sum    = {1'b0, hp_q} + {1'b0, dmgMon};
  assign atk_pass  = (page_q == PG_ATK) && atkPass;
  assign atk_kill  = atk_pass && (hp_sum >= (HP_W+1)'(MON_HP_MAX));

`ifdef BATTLE_SEQ_ATK_TIMEOUT_EN
  localparam int AT_W = $clog2(ATK_TIMEOUT + 1);
  logic [AT_W-1:0] atmr_q, atmr_d;

  assign atk_exp = (page_q == PG_ATK) && !atkPass && (atmr_q <= AT_W'(1));

  always_comb begin
    atmr_d = atmr_q;
    if (act_j && sub_q == 4'd0)                  atmr_d = AT_W'(ATK_TIMEOUT);
    else if (page_q == PG_ATK && atmr_q != '0)   atmr_d = atmr_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) atmr_q <= '0;
    else       atmr_q <= atmr_d;
`else
  assign atk_exp = 1'b0;
`endif

  // State register (FSM plus all registered outputs).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_q <= PG_MENU;  sub_q  <= '0;  dtmr_q <= '0;
      hp_q   <= '0;       rnd_q  <= '0;  win_q  <= 1'b0;
      iv_q   <= 1'b0;     iop_q  <= '0;  iarg_q <= '0;
      mv_q   <= 1'b0;     sd_q   <= 1'b0;
    end else begin
      page_q <= page_d;   sub_q  <= sub_d;  dtmr_q <= dtmr_d;
      hp_q   <= hp_d;     rnd_q  <= rnd_d;  win_q  <= win_d;
      iv_q   <= iv_d;     iop_q  <= iop_d;  iarg_q <= iarg_d;
      mv_q   <= mv_d;     sd_q   <= sd_d;
    end
  end

  // Next-state: page/cursor and dodge timer.
  always_comb begin
    page_d = page_q;
    sub_d  = sub_q;
    dtmr_d = dtmr_q;
    unique case (page_q)
      PG_MENU:  if (key == K_SPACE) begin page_d = PG_START; sub_d = '0; end
      PG_START: begin page_d = PG_ACT; sub_d = '0; end
      PG_ACT: begin
        if (key == K_A)      sub_d = (sub_q == 4'd0) ? 4'd2 : sub_q - 4'd1;
        else if (key == K_D) sub_d = (sub_q >= 4'd2) ? 4'd0 : sub_q + 4'd1;
        else if (key == K_J) begin
          sub_d = '0;
          if (sub_q == 4'd0) page_d = PG_ATK;
          else begin
            page_d = PG_DODGE;
            dtmr_d = DT_W'(DODGE_CYCLES);
          end
        end
      end
      PG_ATK: begin
        if (atk_kill) begin
          page_d = PG_MENU;
          sub_d  = '0;
        end else if (atk_pass || atk_exp) begin
          page_d = PG_DODGE;
          sub_d  = '0;
          dtmr_d = DT_W'(DODGE_CYCLES);
        end
      end
      PG_DODGE: begin
        if (isDeath) begin
          page_d = PG_MENU;
          sub_d  = '0;
        end else if (dodge_exp) begin
          page_d = PG_ACT;
          sub_d  = '0;
        end else begin
          dtmr_d = dtmr_q - 1'b1;
        end
      end
      default: begin page_d = PG_MENU; sub_d = '0; end
    endcase
  end

  // Outputs: HP/win/round accounting, event pulses and the instruction slot.
  always_comb begin
    hp_d  = hp_q;
    win_d = win_q;
    rnd_d = rnd_q;
    mv_d  = dodge_mov;
    sd_d  = dodge_hit;
    if (menu_go) begin
      hp_d  = '0;
      rnd_d = '0;
      win_d = 1'b0;
    end
    if (atk_pass) hp_d = atk_kill ? HP_W'(MON_HP_MAX) : hp_sum[HP_W-1:0];
    if (atk_kill) win_d = 1'b1;
    if (dodge_exp) rnd_d = rnd_q + 1'b1;

    iss     = 1'b0;
    iss_op  = '0;
    iss_arg = '0;
    if ((act_j && sub_q == 4'd1) || (dodge_hit && heal)) begin
      iss = 1'b1; iss_op = OP_HPY; iss_arg = 8'(HEAL_AMT);
    end else if (dodge_hit) begin
      iss = 1'b1; iss_op = OP_DPY; iss_arg = damage;
    end else if (dodge_mov) begin
      iss = 1'b1; iss_op = OP_MOV; iss_arg = {4'd0, key - 4'd1};
    end

    // An entry handed off this cycle no longer blocks or merges with a new issue.
    pend   = iv_q && !instrReady;
    dsum   = {1'b0, iarg_q} + {1'b0, iss_arg};
    iv_d   = pend;
    iop_d  = iop_q;
    iarg_d = iarg_q;
    if (iss) begin
      if (iss_op == OP_MOV && pend && iop_q != OP_MOV) begin
        iv_d = 1'b1;
      end else if (iss_op == OP_DPY && pend && iop_q == OP_DPY) begin
        iv_d   = 1'b1;
        iarg_d = dsum[8] ? 8'hFF : dsum[7:0];
      end else begin
        iv_d   = 1'b1;
        iop_d  = iss_op;
        iarg_d = iss_arg;
      end
    end
  end

  assign state             = {page_q, sub_q};
  assign playerInstruction = {iop_q, iarg_q, 4'h0};
  assign instrValid        = iv_q;
  assign isMove            = mv_q;
  assign monHP             = hp_q;
  assign startDmg          = sd_q;
  assign roundCnt          = rnd_q;
  assign win               = win_q;
endmodule
